// File: rtl/safecrack_pkg.sv
// Shared types and width helpers for the parametrised safe-lock controller.
package safecrack_pkg;

    typedef enum logic [3:0] {
        ENTRY    = 4'b0001,
        UNLOCKED = 4'b0010,
        PROG     = 4'b0100,
        LOCKOUT  = 4'b1000
    } state_t;

    // Width of a counter that must hold 0..n inclusive.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // Width of a down/up timer that must hold 0..n-1.
    function automatic int unsigned tmr_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/safecrack_param_fsm_if.sv
// Button input and status outputs of the safe-lock controller.
interface safecrack_param_fsm_if #(
    parameter int unsigned DIGIT_W   = 4,
    parameter int unsigned CODE_LEN  = 3,
    parameter int unsigned MAX_TRIES = 3
);
    logic [DIGIT_W-1:0]                           btn;
    logic                                         unlocked;
    logic                                         locked_out;
    logic                                         prog_mode;
    logic [safecrack_pkg::cnt_w(MAX_TRIES)-1:0]  fail_cnt;
    logic [safecrack_pkg::cnt_w(CODE_LEN)-1:0]   digit_idx;

    modport master (
        output btn,
        input  unlocked, locked_out, prog_mode, fail_cnt, digit_idx
    );

    modport slave (
        input  btn,
        output unlocked, locked_out, prog_mode, fail_cnt, digit_idx
    );
endinterface

// File: rtl/safecrack_press_det.sv
// Rising-edge press detector: a press is the first cycle btn leaves all-zero.
module safecrack_press_det #(
    parameter int unsigned DIGIT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DIGIT_W-1:0] btn,
    output logic               press,
    output logic [DIGIT_W-1:0] digit
);
    logic [DIGIT_W-1:0] btn_q;

    always_ff @(posedge clk) begin
        if (rst) btn_q <= '0;
        else     btn_q <= btn;
    end

    assign press = (btn != '0) && (btn_q == '0);
    assign digit = btn;
endmodule

// File: rtl/safecrack_param_fsm.sv
// Safe-lock controller: code entry, failure lockout and code reprogramming.
// Optional SAFE_AUTOLOCK_EN adds an idle auto-relock timer in UNLOCKED.
module safecrack_param_fsm
    import safecrack_pkg::*;
#(
    parameter int unsigned                  DIGIT_W      = 4,
    parameter int unsigned                  CODE_LEN     = 3,
    parameter int unsigned                  MAX_TRIES    = 3,
    parameter int unsigned                  LOCKOUT_CYC  = 250,
    parameter int unsigned                  AUTOLOCK_CYC = 1000,
    parameter logic [CODE_LEN*DIGIT_W-1:0]  DEFAULT_CODE = 12'hDD7
) (
    input logic                  clk,
    input logic                  rst,
    safecrack_param_fsm_if.slave bus
);
    localparam int unsigned        FW         = cnt_w(MAX_TRIES);
    localparam int unsigned        IW         = cnt_w(CODE_LEN);
    localparam int unsigned        TW         = tmr_w(LOCKOUT_CYC);
    localparam logic [IW-1:0]      LAST_IDX   = IW'(CODE_LEN - 1);
    localparam logic [FW-1:0]      FAIL_MAX   = FW'(MAX_TRIES);
    localparam logic [TW-1:0]      LOCK_INIT  = TW'(LOCKOUT_CYC - 1);
    localparam logic [DIGIT_W-1:0] PROG_KEY   = DIGIT_W'(1);
    localparam logic [DIGIT_W-1:0] RELOCK_KEY = DIGIT_W'(1) << (DIGIT_W - 1);

    state_t             state, state_n;
    logic [FW-1:0]      fail_q, fail_n;
    logic [IW-1:0]      idx_q, idx_n;
    logic [TW-1:0]      tmr_q, tmr_n;
    logic               buf_we, shd_we, commit, match;
    logic               press;
    logic [DIGIT_W-1:0] digit;
    logic [DIGIT_W-1:0] entry_buf [CODE_LEN];
    logic [DIGIT_W-1:0] shadow    [CODE_LEN];
    logic [DIGIT_W-1:0] code      [CODE_LEN];

`ifdef SAFE_AUTOLOCK_EN
    localparam int unsigned   AW        = tmr_w(AUTOLOCK_CYC);
    localparam logic [AW-1:0] AUTO_LAST = AW'(AUTOLOCK_CYC - 1);
    logic [AW-1:0]            auto_q, auto_n;
`endif

    safecrack_press_det #(.DIGIT_W(DIGIT_W)) u_press (
        .clk   (clk),
        .rst   (rst),
        .btn   (bus.btn),
        .press (press),
        .digit (digit)
    );

    // The final digit is compared straight off btn, so it never needs a buffer slot.
    always_comb begin
        match = (digit == code[CODE_LEN-1]);
        for (int unsigned i = 0; i + 1 < CODE_LEN; i++) begin
            if (entry_buf[i] != code[i]) match = 1'b0;
        end
    end

    always_comb begin
        state_n = state;
        fail_n  = fail_q;
        idx_n   = idx_q;
        tmr_n   = tmr_q;
        buf_we  = 1'b0;
        shd_we  = 1'b0;
        commit  = 1'b0;
`ifdef SAFE_AUTOLOCK_EN
        auto_n  = '0;
`endif
        case (state)
            ENTRY: begin
                if (press) begin
                    if (idx_q == LAST_IDX) begin
                        idx_n = '0;
                        if (match) begin
                            state_n = UNLOCKED;
                            fail_n  = '0;
                        end else begin
                            fail_n = (fail_q == FAIL_MAX) ? FAIL_MAX : fail_q + FW'(1);
                            if (fail_n == FAIL_MAX) begin
                                state_n = LOCKOUT;
                                tmr_n   = LOCK_INIT;
                            end
                        end
                    end else begin
                        buf_we = 1'b1;
                        idx_n  = idx_q + IW'(1);
                    end
                end
            end
            UNLOCKED: begin
                if (press) begin
                    if (digit == PROG_KEY) begin
                        state_n = PROG;
                        idx_n   = '0;
                    end else if (digit == RELOCK_KEY) begin
                        state_n = ENTRY;
                    end
                end
`ifdef SAFE_AUTOLOCK_EN
                else if (auto_q == AUTO_LAST) begin
                    state_n = ENTRY;
                end else begin
                    auto_n = auto_q + AW'(1);
                end
`endif
            end
            PROG: begin
                if (press) begin
                    if (idx_q == LAST_IDX) begin
                        commit  = 1'b1;
                        state_n = ENTRY;
                        idx_n   = '0;
                        fail_n  = '0;
                    end else begin
                        shd_we = 1'b1;
                        idx_n  = idx_q + IW'(1);
                    end
                end
            end
            LOCKOUT: begin
                if (tmr_q == '0) begin
                    state_n = ENTRY;
                    fail_n  = '0;
                end else begin
                    tmr_n = tmr_q - TW'(1);
                end
            end
            default: state_n = ENTRY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ENTRY;
            fail_q <= '0;
            idx_q  <= '0;
            tmr_q  <= '0;
`ifdef SAFE_AUTOLOCK_EN
            auto_q <= '0;
`endif
            for (int unsigned i = 0; i < CODE_LEN; i++) begin
                code[i]      <= DEFAULT_CODE[i*DIGIT_W +: DIGIT_W];
                entry_buf[i] <= '0;
                shadow[i]    <= '0;
            end
        end else begin
            state  <= state_n;
            fail_q <= fail_n;
            idx_q  <= idx_n;
            tmr_q  <= tmr_n;
`ifdef SAFE_AUTOLOCK_EN
            auto_q <= auto_n;
`endif
            for (int unsigned i = 0; i < CODE_LEN; i++) begin
                if (buf_we && idx_q == IW'(i)) entry_buf[i] <= digit;
                if (shd_we && idx_q == IW'(i)) shadow[i]    <= digit;
                // Last digit arrives on btn in the committing cycle.
                if (commit) code[i] <= (i == CODE_LEN - 1) ? digit : shadow[i];
            end
        end
    end

    assign bus.unlocked   = (state == UNLOCKED);
    assign bus.locked_out = (state == LOCKOUT);
    assign bus.prog_mode  = (state == PROG);
    assign bus.fail_cnt   = fail_q;
    assign bus.digit_idx  = idx_q;
endmodule

// File: tb/tb_safecrack_param_fsm.sv
// Scoreboard bench for safecrack_param_fsm (define SAFE_AUTOLOCK_EN for the auto-relock build).
module tb_safecrack_param_fsm;
`ifdef SAFE_AUTOLOCK_EN
    localparam int unsigned AC = 16;
`else
    localparam int unsigned AC = 1000;
`endif
    localparam int unsigned RESTART = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    logic [6:0] sb [$];

    always #5 clk = ~clk;

    safecrack_param_fsm_if #(.DIGIT_W(4), .CODE_LEN(3), .MAX_TRIES(3)) bus ();

    safecrack_param_fsm #(
        .DIGIT_W      (4),
        .CODE_LEN     (3),
        .MAX_TRIES    (3),
        .LOCKOUT_CYC  (250),
        .AUTOLOCK_CYC (AC),
        .DEFAULT_CODE (12'hDD7)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic logic [6:0] ex(input logic u, input logic lo, input logic pm,
                                      input logic [1:0] fc, input logic [1:0] di);
        return {u, lo, pm, fc, di};
    endfunction

    function automatic logic [6:0] obs();
        return {bus.unlocked, bus.locked_out, bus.prog_mode, bus.fail_cnt, bus.digit_idx};
    endfunction

    // One released cycle, then one pressed cycle; returns at the negedge after the press edge.
    task automatic press(input logic [3:0] d);
        bus.btn = '0;
        @(negedge clk);
        bus.btn = d;
        @(negedge clk);
        bus.btn = '0;
    endtask

    task automatic test_reset();
        logic [6:0] e;
        rst = 1'b1;
        bus.btn = '0;
        repeat (3) @(negedge clk);
        sb.push_back(ex(0, 0, 0, 0, 0));
        e = sb.pop_front();
        tests++;
        if (obs() !== e) begin
            fails++;
            $display("FAIL reset_hold: got %b expected %b", obs(), e);
        end
        rst = 1'b0;
        sb.push_back(ex(0, 0, 0, 0, 0));
        @(negedge clk);
        e = sb.pop_front();
        tests++;
        if (obs() !== e) begin
            fails++;
            $display("FAIL reset_release: got %b expected %b", obs(), e);
        end
    endtask

    task automatic test_unlock();
        logic [3:0] seq [5];
        logic [6:0] exp [5];
        logic [6:0] e;
        seq = '{4'h7, 4'hD, 4'hD, 4'h2, 4'h8};
        exp = '{ex(0,0,0,0,1), ex(0,0,0,0,2), ex(1,0,0,0,0), ex(1,0,0,0,0), ex(0,0,0,0,0)};
        for (int i = 0; i < 5; i++) begin
            sb.push_back(exp[i]);
            press(seq[i]);
            e = sb.pop_front();
            tests++;
            if (obs() !== e) begin
                fails++;
                $display("FAIL unlock[%0d]: got %b expected %b", i, obs(), e);
            end
        end
    endtask

    task automatic test_hold();
        logic [3:0] seq [3];
        logic [6:0] exp [3];
        logic [6:0] e;
        bus.btn = '0;
        @(negedge clk);
        sb.push_back(ex(0, 0, 0, 0, 1));
        bus.btn = 4'h7;
        repeat (10) @(negedge clk);
        bus.btn = 4'h5;
        repeat (10) @(negedge clk);
        e = sb.pop_front();
        tests++;
        if (obs() !== e) begin
            fails++;
            $display("FAIL hold: got %b expected %b", obs(), e);
        end
        seq = '{4'hD, 4'hD, 4'h8};
        exp = '{ex(0,0,0,0,2), ex(1,0,0,0,0), ex(0,0,0,0,0)};
        for (int i = 0; i < 3; i++) begin
            sb.push_back(exp[i]);
            press(seq[i]);
            e = sb.pop_front();
            tests++;
            if (obs() !== e) begin
                fails++;
                $display("FAIL hold_seq[%0d]: got %b expected %b", i, obs(), e);
            end
        end
    endtask

    task automatic test_lockout();
        logic [6:0] exp [9];
        logic [3:0] seq [4];
        logic [6:0] post [4];
        logic [6:0] e;
        int cnt;
        logic idx_moved;
        exp = '{ex(0,0,0,0,1), ex(0,0,0,0,2), ex(0,0,0,1,0),
                ex(0,0,0,1,1), ex(0,0,0,1,2), ex(0,0,0,2,0),
                ex(0,0,0,2,1), ex(0,0,0,2,2), ex(0,1,0,3,0)};
        for (int i = 0; i < 9; i++) begin
            sb.push_back(exp[i]);
            press(4'h1);
            e = sb.pop_front();
            tests++;
            if (obs() !== e) begin
                fails++;
                $display("FAIL wrong[%0d]: got %b expected %b", i, obs(), e);
            end
        end
        sb.push_back(7'(250));
        cnt = 0;
        idx_moved = 1'b0;
        while (bus.locked_out === 1'b1 && cnt < 1000) begin
            cnt++;
            if (bus.digit_idx !== 2'd0) idx_moved = 1'b1;
            bus.btn = (cnt == 3 || cnt == 120) ? 4'h7 : 4'h0;
            @(negedge clk);
        end
        e = sb.pop_front();
        tests++;
        if (7'(cnt) !== e) begin
            fails++;
            $display("FAIL lockout_len: got %0d cycles expected %0d", cnt, e);
        end
        tests++;
        if (idx_moved !== 1'b0) begin
            fails++;
            $display("FAIL lockout_ignore: got digit_idx change expected none");
        end
        sb.push_back(ex(0, 0, 0, 0, 0));
        e = sb.pop_front();
        tests++;
        if (obs() !== e) begin
            fails++;
            $display("FAIL lockout_exit: got %b expected %b", obs(), e);
        end
        seq  = '{4'h7, 4'hD, 4'hD, 4'h8};
        post = '{ex(0,0,0,0,1), ex(0,0,0,0,2), ex(1,0,0,0,0), ex(0,0,0,0,0)};
        for (int i = 0; i < 4; i++) begin
            sb.push_back(post[i]);
            press(seq[i]);
            e = sb.pop_front();
            tests++;
            if (obs() !== e) begin
                fails++;
                $display("FAIL after_lockout[%0d]: got %b expected %b", i, obs(), e);
            end
        end
    endtask

    task automatic test_prog();
        logic [3:0] seq [14];
        logic [6:0] exp [14];
        logic [6:0] e;
        seq = '{4'h7, 4'hD, 4'hD, 4'h1, 4'h3, 4'h5, 4'h9,
                4'h7, 4'hD, 4'hD, 4'h3, 4'h5, 4'h9, 4'h8};
        exp = '{ex(0,0,0,0,1), ex(0,0,0,0,2), ex(1,0,0,0,0), ex(0,0,1,0,0),
                ex(0,0,1,0,1), ex(0,0,1,0,2), ex(0,0,0,0,0),
                ex(0,0,0,0,1), ex(0,0,0,0,2), ex(0,0,0,1,0),
                ex(0,0,0,1,1), ex(0,0,0,1,2), ex(1,0,0,0,0), ex(0,0,0,0,0)};
        for (int i = 0; i < 14; i++) begin
            sb.push_back(exp[i]);
            press(seq[i]);
            e = sb.pop_front();
            tests++;
            if (obs() !== e) begin
                fails++;
                $display("FAIL prog[%0d]: got %b expected %b", i, obs(), e);
            end
        end
    endtask

    task automatic test_prog_reset();
        logic [3:0] seq [6];
        logic [6:0] exp [6];
        logic [3:0] seq2 [4];
        logic [6:0] exp2 [4];
        logic [6:0] e;
        seq = '{4'h3, 4'h5, 4'h9, 4'h1, 4'h2, 4'h4};
        exp = '{ex(0,0,0,0,1), ex(0,0,0,0,2), ex(1,0,0,0,0),
                ex(0,0,1,0,0), ex(0,0,1,0,1), ex(0,0,1,0,2)};
        for (int i = 0; i < 6; i++) begin
            sb.push_back(exp[i]);
            press(seq[i]);
            e = sb.pop_front();
            tests++;
            if (obs() !== e) begin
                fails++;
                $display("FAIL prog_partial[%0d]: got %b expected %b", i, obs(), e);
            end
        end
        sb.push_back(ex(0, 0, 0, 0, 0));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        e = sb.pop_front();
        tests++;
        if (obs() !== e) begin
            fails++;
            $display("FAIL prog_reset: got %b expected %b", obs(), e);
        end
        seq2 = '{4'h7, 4'hD, 4'hD, 4'h8};
        exp2 = '{ex(0,0,0,0,1), ex(0,0,0,0,2), ex(1,0,0,0,0), ex(0,0,0,0,0)};
        for (int i = 0; i < 4; i++) begin
            sb.push_back(exp2[i]);
            press(seq2[i]);
            e = sb.pop_front();
            tests++;
            if (obs() !== e) begin
                fails++;
                $display("FAIL default_code[%0d]: got %b expected %b", i, obs(), e);
            end
        end
    endtask

    task automatic test_autolock();
        logic [3:0] seq [3];
        logic [6:0] e;
        int cnt;
        int limit;
        seq = '{4'h7, 4'hD, 4'hD};
        for (int i = 0; i < 3; i++) press(seq[i]);
`ifdef SAFE_AUTOLOCK_EN
        limit = 200;
        sb.push_back(7'(RESTART + AC));
`else
        limit = 40;
        sb.push_back(7'(40));
`endif
        cnt = 0;
        while (bus.unlocked === 1'b1 && cnt < limit) begin
            cnt++;
            bus.btn = (cnt == RESTART) ? 4'h2 : 4'h0;
            @(negedge clk);
        end
        e = sb.pop_front();
        tests++;
        if (7'(cnt) !== e) begin
            fails++;
            $display("FAIL autolock_len: got %0d cycles expected %0d", cnt, e);
        end
`ifndef SAFE_AUTOLOCK_EN
        press(4'h8);
`endif
        sb.push_back(ex(0, 0, 0, 0, 0));
        e = sb.pop_front();
        tests++;
        if (obs() !== e) begin
            fails++;
            $display("FAIL autolock_exit: got %b expected %b", obs(), e);
        end
    endtask

    initial begin
        bus.btn = '0;
        test_reset();
        test_unlock();
        test_hold();
        test_lockout();
        test_prog();
        test_prog_reset();
        test_autolock();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
